// File: rtl/cp_remover_if.sv
// Sample streams around the cyclic-prefix remover: i_* carries detector samples in,
// o_* carries framed FFT windows out.
interface cp_remover_if;
  // Valid/ready: a beat transfers on a clk edge where tvalid && tready are both 1;
  // once tvalid is raised, tdata/tlast stay stable until that edge.
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/cp_remover.sv
// Strips the cyclic prefix from each OFDM symbol and frames FFT_SIZE samples per window.
// Optional CP_REMOVER_OFFSET_EN adds cp_offset to start the window early inside the CP.
module cp_remover #(
  parameter int FFT_SIZE = 1024,
  parameter int CP_SIZE  = 128
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  cp_remover_if.slave                      bus,
`ifdef CP_REMOVER_OFFSET_EN
  input  logic [$clog2(CP_SIZE+1)-1:0]     cp_offset,
`endif
  output logic [15:0]                      sym_count,
  output logic                             err_short,
  output logic [1:0]                       state_dbg
);

  localparam int SYM   = CP_SIZE + FFT_SIZE;
  localparam int IDX_W = $clog2(SYM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM - 1);
  localparam logic [IDX_W-1:0] CP_IDX   = IDX_W'(CP_SIZE);

  typedef enum logic [1:0] {IDLE = 2'd0, CP = 2'd1, DATA = 2'd2, TAIL = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] k_eff, keep_lo, keep_hi;
  logic             keep, win_last, in_hs;

`ifdef CP_REMOVER_OFFSET_EN
  localparam int KW = $clog2(CP_SIZE + 1);
  logic [KW-1:0] k_q, k_clamp;

  assign k_clamp = (cp_offset > KW'(CP_SIZE)) ? KW'(CP_SIZE) : cp_offset;
  // The live offset applies to the packet's first beat; it is frozen from then on.
  assign k_eff   = (state_q == IDLE) ? IDX_W'(k_clamp) : IDX_W'(k_q);

  always_ff @(posedge clk) begin
    if (!reset_n) k_q <= '0;
    else if (in_hs && state_q == IDLE) k_q <= k_clamp;
  end
`else
  assign k_eff = '0;
`endif

  assign keep_lo   = CP_IDX - k_eff;
  assign keep_hi   = LAST_IDX - k_eff;
  assign keep      = (idx_q >= keep_lo) && (idx_q <= keep_hi);
  assign win_last  = keep && ((idx_q == keep_hi) || bus.i_tlast);
  assign state_dbg = state_q;

  always_comb begin
    bus.i_tready = keep ? (!bus.o_tvalid || bus.o_tready) : 1'b1;
    in_hs        = bus.i_tvalid && bus.i_tready;
    idx_d        = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    state_d      = state_q;
    if (in_hs) begin
      if (bus.i_tlast)                           state_d = IDLE;
      else if (idx_d >= keep_lo && idx_d <= keep_hi) state_d = DATA;
      else if (idx_d > keep_hi)                  state_d = TAIL;
      else                                       state_d = CP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      bus.o_tvalid <= 1'b0;
      bus.o_tlast  <= 1'b0;
      bus.o_tdata  <= '0;
      sym_count    <= '0;
      if (!reset_n) err_short <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_hs) begin
        idx_q <= bus.i_tlast ? '0 : idx_d;
        if (bus.i_tlast && idx_q != LAST_IDX) err_short <= 1'b1;
      end
      if (in_hs && keep) begin
        bus.o_tvalid <= 1'b1;
        bus.o_tdata  <= bus.i_tdata;
        bus.o_tlast  <= win_last;
      end else if (bus.o_tready) begin
        bus.o_tvalid <= 1'b0;
      end
      // The first beat of a packet restarts the symbol count.
      if (in_hs && state_q == IDLE)
        sym_count <= (keep && win_last) ? 16'd1 : 16'd0;
      else if (in_hs && keep && win_last && sym_count != 16'hFFFF)
        sym_count <= sym_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cp_remover.sv
// Bench for cp_remover: random valid/ready traffic against a sample-index window model.
module tb_cp_remover;
  localparam int FFT_SIZE = 1024;
  localparam int CP_SIZE  = 128;
  localparam int SYM      = FFT_SIZE + CP_SIZE;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] sym_count;
  logic        err_short;
  logic [1:0]  state_dbg;
`ifdef CP_REMOVER_OFFSET_EN
  logic [7:0]  cp_offset = 8'd0;
`endif

  cp_remover_if bus();

  cp_remover #(.FFT_SIZE(FFT_SIZE), .CP_SIZE(CP_SIZE)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .bus(bus),
`ifdef CP_REMOVER_OFFSET_EN
    .cp_offset(cp_offset),
`endif
    .sym_count(sym_count),
    .err_short(err_short),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [32:0] exp_q[$];
  int          out_cnt = 0;
  int          exp_sym = 0;
  logic        exp_err = 1'b0;
  int          pkt_len = 0;
  int          pkt_n = 0;
  int          vld_pct = 100;
  int          rdy_pct = 100;
  int          cur_k = 0;
  bit          pkt_tlast = 1'b0;
  logic [15:0] pkt_tag = 16'd0;
  logic        held_v = 1'b0;
  logic [32:0] held_w = '0;

  function automatic logic [31:0] sample(int n);
    return {pkt_tag, 16'(n)};
  endfunction

  // Reference: a sample survives when its position in the symbol lies inside the window.
  function automatic void model_accept(int n, logic is_last);
    int   idx = n % SYM;
    int   lo  = CP_SIZE - cur_k;
    int   hi  = SYM - 1 - cur_k;
    logic wl;
    if (n == 0) exp_sym = 0;
    if (idx >= lo && idx <= hi) begin
      wl = (idx == hi) || is_last;
      exp_q.push_back({wl, sample(n)});
      if (wl && exp_sym < 65535) exp_sym++;
    end
    if (is_last && idx != SYM - 1) exp_err = 1'b1;
  endfunction

  task automatic step();
    logic        acc;
    logic [32:0] got, want;
    @(negedge clk);
    got = {bus.o_tlast, bus.o_tdata};
    if (held_v) begin
      total++;
      if (!bus.o_tvalid || got !== held_w) begin
        bad++;
        $display("FAIL hold_stable: got valid=%0b beat=%h, want valid=1 beat=%h", bus.o_tvalid, got, held_w);
      end
    end
    held_v = 1'b0;
    if (bus.o_tvalid && bus.o_tready) begin
      total++;
      out_cnt++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_extra: got beat=%h, want no beat", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL out_beat: got {last,data}=%h, want %h", got, want);
        end
      end
    end else if (bus.o_tvalid) begin
      held_v = 1'b1;
      held_w = got;
    end
    acc = bus.i_tvalid && bus.i_tready;
    if (acc) begin
      model_accept(pkt_n, bus.i_tlast);
      pkt_n++;
    end
    @(posedge clk);
    #1;
    bus.o_tready = (int'($urandom_range(99)) < rdy_pct);
    if (pkt_n < pkt_len) begin
      if (!(bus.i_tvalid && !acc)) bus.i_tvalid = (int'($urandom_range(99)) < vld_pct);
      bus.i_tdata = sample(pkt_n);
      bus.i_tlast = pkt_tlast && (pkt_n == pkt_len - 1);
    end else begin
      bus.i_tvalid = 1'b0;
      bus.i_tlast  = 1'b0;
    end
  endtask

  task automatic run_packet(int len, bit with_last, int vp, int rp, int k);
    int budget = 0;
    int lim = len * 20 + 2000;
    pkt_len   = len;
    pkt_n     = 0;
    pkt_tlast = with_last;
    vld_pct   = vp;
    rdy_pct   = rp;
    pkt_tag   = 16'($urandom());
    cur_k     = (k > CP_SIZE) ? CP_SIZE : k;
`ifdef CP_REMOVER_OFFSET_EN
    cp_offset = 8'(k);
`endif
    while ((pkt_n < len || exp_q.size() != 0 || bus.o_tvalid) && budget < lim) begin
      step();
      budget++;
    end
    total++;
    if (budget >= lim) begin
      bad++;
      $display("FAIL timeout: got sent=%0d pending=%0d, want sent=%0d pending=0", pkt_n, exp_q.size(), len);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.i_tvalid = 1'b0;
    bus.i_tdata = '0;
    bus.i_tlast = 1'b0;
    bus.o_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total += 6;
    if (bus.o_tvalid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.o_tvalid); end
    if (bus.o_tlast !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", bus.o_tlast); end
    if (bus.o_tdata !== 32'd0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.o_tdata); end
    if (sym_count !== 16'd0) begin bad++; $display("FAIL rst_sym: got %0d want 0", sym_count); end
    if (err_short !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_short); end
    if (state_dbg !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    reset_n = 1'b1;
  endtask

  task automatic test_ramp(string name, int nsym, int vp, int rp, int k);
    int o0 = out_cnt;
    run_packet(nsym * SYM, 1'b1, vp, rp, k);
    total += 4;
    if (out_cnt - o0 !== nsym * FFT_SIZE) begin bad++; $display("FAIL %s_count: got %0d want %0d", name, out_cnt - o0, nsym * FFT_SIZE); end
    if (sym_count !== 16'(nsym)) begin bad++; $display("FAIL %s_sym: got %0d want %0d", name, sym_count, nsym); end
    if (err_short !== exp_err) begin bad++; $display("FAIL %s_err: got %b want %b", name, err_short, exp_err); end
    if (state_dbg !== 2'd0) begin bad++; $display("FAIL %s_state: got %0d want 0", name, state_dbg); end
  endtask

  task automatic test_short();
    int o0 = out_cnt;
    run_packet(601, 1'b1, 100, 100, 0);
    total += 4;
    if (out_cnt - o0 !== 473) begin bad++; $display("FAIL short_count: got %0d want 473", out_cnt - o0); end
    if (sym_count !== 16'(exp_sym) || sym_count !== 16'd1) begin bad++; $display("FAIL short_sym: got %0d want 1", sym_count); end
    if (err_short !== 1'b1) begin bad++; $display("FAIL short_err: got %b want 1", err_short); end
    if (state_dbg !== 2'd0) begin bad++; $display("FAIL short_state: got %0d want 0", state_dbg); end
    test_ramp("after_short", 2, 100, 100, 0);
  endtask

  task automatic test_abort(bit use_clear);
    int budget = 0;
    run_packet(700, 1'b0, 100, 100, 0);
    rdy_pct = 0;
    pkt_len = 701;
    while (pkt_n < 701 && budget < 50) begin
      step();
      budget++;
    end
    total++;
    if (pkt_n != 701) begin bad++; $display("FAIL abort_accept: got sent=%0d want 701", pkt_n); end
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    if (use_clear) clear = 1'b1;
    else begin
      reset_n = 1'b0;
      exp_err = 1'b0;
    end
    bus.i_tvalid = 1'b0;
    @(posedge clk);
    #1;
    total += 4;
    if (bus.o_tvalid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", bus.o_tvalid); end
    if (state_dbg !== 2'd0) begin bad++; $display("FAIL abort_state: got %0d want 0", state_dbg); end
    if (sym_count !== 16'd0) begin bad++; $display("FAIL abort_sym: got %0d want 0", sym_count); end
    if (err_short !== exp_err) begin bad++; $display("FAIL abort_err: got %b want %b", err_short, exp_err); end
    clear = 1'b0;
    reset_n = 1'b1;
    held_v = 1'b0;
    exp_q.delete();
    test_ramp("after_abort", 2, 100, 100, 0);
  endtask

  initial begin
    test_reset();
    test_ramp("ramp", 2, 100, 100, 0);
    test_ramp("random_flow", 2, 70, 50, 0);
    test_ramp("long", 3, 100, 100, 0);
    test_ramp("back_to_back", 1, 100, 100, 0);
`ifdef CP_REMOVER_OFFSET_EN
    test_ramp("offset16", 2, 100, 100, 16);
    test_ramp("offset_clamp", 2, 100, 100, 200);
    test_ramp("offset_random", 2, 70, 50, 40);
`endif
    test_short();
    test_abort(1'b1);
    test_abort(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
